// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Holds the FSM state encoding, the grant-side encoding and the default
// widths used by mem_port_arbiter and its optional stall-cycle counters.
package mem_arb_pkg;

  // Default geometry of the unified memory port.
  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  // Consecutive D grants allowed while a fetch waits before I is forced in.
  localparam int unsigned DEF_D_BURST = 4;

  // Arbiter FSM states: idle, or one access in flight for the I or D side.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  // Which side (if any) wins the memory port on the current IDLE cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_side_e;

  // True while an access owns the memory port.
  function automatic logic is_busy(input arb_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Free-running 32-bit event counter used to accumulate stall cycles.
// Counts every clock with en_i high, wraps modulo 2^32, cleared by the
// synchronous active-high reset. Only instantiated when MEM_ARB_PERF_EN
// is defined.
module mem_arb_perf_cnt (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: increment on an enabled cycle, natural wrap at 2^32.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch (I)
// and data (D) sides of the pipeline.
// - D has priority; after D_BURST back-to-back D grants with a fetch
//   waiting, the next grant is forced to I so fetch always progresses.
// - One access in flight at a time; the grant edge registers the address,
//   write strobe and write data onto mem_*, which then stay stable while
//   mem_req is high.
// - Handshake: a requester raises x_req and holds it (with stable payload)
//   until the single-cycle x_ready pulse; the memory sees mem_req held
//   until a single-cycle mem_ack, which may arrive in the first mem_req
//   cycle and completes the access in that same cycle.
// - proto_err is sticky: set by mem_ack while idle, or by a granted
//   requester dropping its request before its ready pulse.
// Optional build macro MEM_ARB_PERF_EN adds perf_if_wait / perf_d_wait,
// counting cycles with if_stall / d_stall high.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned D_BURST = DEF_D_BURST
) (
  input  logic              clock,
  input  logic              reset,
  // Instruction-fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  // Data side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  // Memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  // Status / debug
  output arb_state_e        dbg_state,
  output logic              proto_err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait
`endif
);

  // Counter just wide enough to hold D_BURST (saturating value).
  localparam int unsigned CNT_W = (D_BURST < 1) ? 1 : $clog2(D_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(D_BURST);

  arb_state_e        state_q, state_d;
  gnt_side_e         gnt;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              burst_full;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              proto_err_q, proto_err_d;

  assign burst_full = (burst_cnt_q == BURST_MAX);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and grant decision: D wins unless a waiting fetch has
  // already seen D_BURST consecutive D grants.
  always_comb begin
    state_d = state_q;
    gnt     = GNT_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (d_req && !(if_req && burst_full)) begin
          gnt     = GNT_D;
          state_d = ST_BUSY_D;
        end else if (if_req) begin
          gnt     = GNT_I;
          state_d = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: ready pulses coincide with mem_ack; read data is gated
  // to zero outside the ready cycle and for stores.
  always_comb begin
    mem_req  = is_busy(state_q);
    if_ready = (state_q == ST_BUSY_I) && mem_ack;
    d_ready  = (state_q == ST_BUSY_D) && mem_ack;
    if_rdata = '0;
    d_rdata  = '0;
    if (if_ready) begin
      if_rdata = mem_rdata;
    end
    if (d_ready && !mem_we_q) begin
      d_rdata = mem_rdata;
    end
    if_stall = if_req && !if_ready;
    d_stall  = d_req && !d_ready;
  end

  // Burst counter: counts D grants taken while a fetch is waiting, and is
  // cleared whenever I is served or D is served with no fetch pending.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    unique case (gnt)
      GNT_I: burst_cnt_d = '0;
      GNT_D: begin
        if (!if_req) begin
          burst_cnt_d = '0;
        end else if (!burst_full) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: burst_cnt_d = burst_cnt_q;
    endcase
  end

  // Sticky protocol error: stray ack while idle, or owner dropped request.
  always_comb begin
    proto_err_d = proto_err_q;
    if ((state_q == ST_IDLE) && mem_ack) begin
      proto_err_d = 1'b1;
    end
    if ((state_q == ST_BUSY_I) && !if_req) begin
      proto_err_d = 1'b1;
    end
    if ((state_q == ST_BUSY_D) && !d_req) begin
      proto_err_d = 1'b1;
    end
  end

  // Burst counter and error flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      burst_cnt_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Memory command registers: captured on the grant edge, held otherwise,
  // so the memory sees a stable command for the whole access.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (gnt)
        GNT_D: begin
          mem_we_q    <= d_we;
          mem_addr_q  <= d_addr;
          mem_wdata_q <= d_wdata;
        end
        GNT_I: begin
          mem_we_q    <= 1'b0;
          mem_addr_q  <= if_addr;
          mem_wdata_q <= '0;
        end
        default: begin
          mem_we_q    <= mem_we_q;
          mem_addr_q  <= mem_addr_q;
          mem_wdata_q <= mem_wdata_q;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign proto_err = proto_err_q;
  assign dbg_state = state_q;

`ifdef MEM_ARB_PERF_EN
  // Stall-cycle counters for performance monitoring.
  mem_arb_perf_cnt u_perf_if (
    .clock_i (clock),
    .reset_i (reset),
    .en_i    (if_stall),
    .count_o (perf_if_wait)
  );

  mem_arb_perf_cnt u_perf_d (
    .clock_i (clock),
    .reset_i (reset),
    .en_i    (d_stall),
    .count_o (perf_d_wait)
  );
`endif

endmodule
